// File: rtl/au_serial_seq_if.sv
// au_serial_seq_if: operand/control bundle between an operand source (master) and the serial sequencer (slave)
interface au_serial_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (output start, a, b, sel, cin, input busy, done, result, cout, ovf);
    modport slave  (input start, a, b, sel, cin, output busy, done, result, cout, ovf);
endinterface

// File: rtl/au_serial_seq.sv
// au_serial_seq: bit-serial add/sub/inc/dec built from a 1-bit AU slice, LSB first, one bit per clock
// Defining AU_SERIAL_OVF_EN builds the registered signed-overflow flag; otherwise ovf is tied low.
module au_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    au_serial_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sr, r_result;
    logic [1:0]       r_sel;
    logic             r_c, r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_y, w_d, w_cn, w_last, w_busy, w_done, w_fin;
    logic [WIDTH-1:0] w_sr_next;

    // sel[1] forces Y to the constant sel[0]; otherwise Y is b optionally inverted by sel[0]
    assign w_y       = r_sel[1] ? r_sel[0] : r_b[0] ^ r_sel[0];
    assign w_d       = r_a[0] ^ w_y ^ r_c;
    assign w_cn      = (r_a[0] & w_y) | (r_a[0] & r_c) | (w_y & r_c);
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign w_fin     = w_busy && w_last;
    assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_busy = r_state == SHIFT;
        w_done = r_state == DONE;
        w_next = (r_state == IDLE && bus.start) ? SHIFT :
                 (w_busy && w_last)             ? DONE  :
                 w_done                         ? IDLE  : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sr     <= '0;
            r_sel    <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_sel <= bus.sel;
            r_c   <= bus.cin;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sr  <= w_sr_next;
            r_c   <= w_cn;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_result <= w_sr_next;
                r_cout   <= w_cn;
            end
        end
    end

`ifdef AU_SERIAL_OVF_EN
    logic r_ovf;

    // carry into the MSB is r_c on the final step; ovf is that XOR the MSB carry-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (w_fin)
            r_ovf <= r_c ^ w_cn;
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
endmodule

// File: tb/tb_au_serial_seq.sv
// tb_au_serial_seq: directed vectors for au_serial_seq with a queue scoreboard checked on each done pulse
module tb_au_serial_seq;
    localparam int W = 8;

`ifdef AU_SERIAL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   n_push = 0;
    exp_t q[$];

    au_serial_seq_if #(.WIDTH(W)) bus();

    au_serial_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            chk("busy_with_done", bus.busy, 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %0h with empty scoreboard", bus.result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", bus.result, e.r);
                chk("cout", bus.cout, e.c);
                chk("ovf", bus.ovf, e.o);
            end
        end
    end

    // Assumes it is entered right after a falling edge with the DUT in IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic [1:0] ts,
                          input logic tc, input logic [W-1:0] er, input logic ec, input logic eo,
                          input bit repulse);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_in;
        bus.sel   = ts;
        bus.cin   = tc;
        @(posedge clk);
        e.r = er;
        e.c = ec;
        e.o = OVF_EN ? eo : 1'b0;
        q.push_back(e);
        n_push++;
        #1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_in;
        bus.sel   = ~ts;
        bus.cin   = ~tc;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (repulse && (k == 3 || k == 9)) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
                bus.sel   = 2'b11;
                bus.cin   = 1'b1;
            end else
                bus.start = 1'b0;
            chk($sformatf("busy_k%0d", k), bus.busy, int'(k <= W));
            chk($sformatf("done_k%0d", k), bus.done, int'(k == W + 1));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sel   = '0;
        bus.cin   = 1'b0;
        #3;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h3C, 8'h05, 2'b00, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        run_op(8'h50, 8'h30, 2'b01, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 2'b01, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h5A, 2'b10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h00, 8'hC3, 2'b11, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(8'h11, 8'h22, 2'b00, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        chk("hold_result", bus.result, 8'h33);
        // abort: accepted operation is killed by reset, so nothing is pushed
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'h0F;
        bus.sel   = 2'b00;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_cout", bus.cout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h01, 8'h01, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        chk("done_count", n_done, n_push);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
